// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI-Lite slave and its backend bridge.
package axilite_pkg;

  typedef enum logic {
    WR_IDLE,
    WR_REQ
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_RESP
  } rd_state_e;

  localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/axilite_slave_if.sv
// AXI-Lite bus without B channel or RRESP; master drives requests, slave drives readies and data.
interface axilite_slave_if;

  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    output axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

endinterface

// File: rtl/axilite_timeout_cnt.sv
// Backend wait counter: cleared by start, counts while run, flags timeout on the last allowed
// cycle unless ack arrives in that same cycle.
module axilite_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout = run && !ack && (cnt_q == CntMax);

endmodule

// File: rtl/axilite_slave.sv
// AXI-Lite slave bridging to a simple request/ack backend, with independent read and write
// paths, each guarded by a backend timeout.
module axilite_slave
  import axilite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  axilite_slave_if.slave        axi,
  output logic                  bk_wreq,
  output logic [31:0]           bk_waddr,
  output logic [31:0]           bk_wdata,
  output logic [3:0]            bk_wstrb,
  input  logic                  bk_wack,
  output logic                  bk_rreq,
  output logic [31:0]           bk_raddr,
  input  logic                  bk_rack,
  input  logic [31:0]           bk_rdata,
  output logic                  err_wtimeout,
  output logic                  err_rtimeout
);

  // Write side: one-entry AW and W buffers
  logic        aw_full_q, w_full_q;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  wr_state_e   wr_state_q;
  logic        bk_wreq_q, err_wtimeout_q;
  logic [31:0] bk_waddr_q, bk_wdata_q;
  logic [3:0]  bk_wstrb_q;
  logic        wr_start, wr_run, wr_timeout, wr_done;

  rd_state_e   rd_state_q;
  logic        bk_rreq_q, err_rtimeout_q;
  logic [31:0] bk_raddr_q, rdata_q;
  logic        rd_start, rd_run, rd_timeout;

  assign axi.axi_awready = ~aw_full_q;
  assign axi.axi_wready  = ~w_full_q;

  assign wr_start = (wr_state_q == WR_IDLE) && aw_full_q && w_full_q;
  assign wr_run   = (wr_state_q == WR_REQ);
  assign wr_done  = wr_run && (bk_wack || wr_timeout);

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (axi.axi_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi.axi_awaddr;
      end
      if (axi.axi_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= axi.axi_wdata;
        w_strb_q <= axi.axi_wstrb;
      end
      // Buffers are both full in WR_REQ, so freeing them cannot race a new capture
      if (wr_done) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_state_q     <= WR_IDLE;
      bk_wreq_q      <= 1'b0;
      bk_waddr_q     <= '0;
      bk_wdata_q     <= '0;
      bk_wstrb_q     <= '0;
      err_wtimeout_q <= 1'b0;
    end else begin
      err_wtimeout_q <= 1'b0;
      unique case (wr_state_q)
        WR_IDLE: begin
          if (wr_start) begin
            wr_state_q <= WR_REQ;
            bk_wreq_q  <= 1'b1;
            bk_waddr_q <= aw_addr_q;
            bk_wdata_q <= w_data_q;
            bk_wstrb_q <= w_strb_q;
          end
        end
        WR_REQ: begin
          if (bk_wack || wr_timeout) begin
            wr_state_q     <= WR_IDLE;
            bk_wreq_q      <= 1'b0;
            bk_waddr_q     <= '0;
            bk_wdata_q     <= '0;
            bk_wstrb_q     <= '0;
            err_wtimeout_q <= wr_timeout;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  axilite_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wr_timeout (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .start   (wr_start),
    .run     (wr_run),
    .ack     (bk_wack),
    .timeout (wr_timeout)
  );

  // Read side
  assign rd_start = (rd_state_q == RD_IDLE) && axi.axi_arvalid;
  assign rd_run   = (rd_state_q == RD_REQ);

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_state_q     <= RD_IDLE;
      bk_rreq_q      <= 1'b0;
      bk_raddr_q     <= '0;
      rdata_q        <= '0;
      err_rtimeout_q <= 1'b0;
    end else begin
      err_rtimeout_q <= 1'b0;
      unique case (rd_state_q)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state_q <= RD_REQ;
            bk_rreq_q  <= 1'b1;
            bk_raddr_q <= axi.axi_araddr;
          end
        end
        RD_REQ: begin
          if (bk_rack || rd_timeout) begin
            rd_state_q     <= RD_RESP;
            bk_rreq_q      <= 1'b0;
            bk_raddr_q     <= '0;
            rdata_q        <= bk_rack ? bk_rdata : TIMEOUT_RDATA;
            err_rtimeout_q <= rd_timeout;
          end
        end
        RD_RESP: begin
          if (axi.axi_rready) begin
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  axilite_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_timeout (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .start   (rd_start),
    .run     (rd_run),
    .ack     (bk_rack),
    .timeout (rd_timeout)
  );

  assign axi.axi_arready = (rd_state_q == RD_IDLE);
  assign axi.axi_rvalid  = (rd_state_q == RD_RESP);
  assign axi.axi_rdata   = rdata_q;

  assign bk_wreq      = bk_wreq_q;
  assign bk_waddr     = bk_waddr_q;
  assign bk_wdata     = bk_wdata_q;
  assign bk_wstrb     = bk_wstrb_q;
  assign bk_rreq      = bk_rreq_q;
  assign bk_raddr     = bk_raddr_q;
  assign err_wtimeout = err_wtimeout_q;
  assign err_rtimeout = err_rtimeout_q;

endmodule

// File: tb/tb_axilite_slave.sv
// Directed plus randomized bench for axilite_slave; expectations come from the transaction-level
// rules (ack within the timeout window returns real data, otherwise timeout data and an error).
module tb_axilite_slave;

  localparam int TO = 4;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        bk_wreq, bk_rreq, bk_wack, bk_rack;
  logic [31:0] bk_waddr, bk_wdata, bk_raddr, bk_rdata;
  logic [3:0]  bk_wstrb;
  logic        err_wtimeout, err_rtimeout;

  int n_checks = 0;
  int n_pass   = 0;

  axilite_slave_if axi ();

  axilite_slave #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .axi_aclk     (clk),
    .axi_areset   (rst),
    .axi          (axi),
    .bk_wreq      (bk_wreq),
    .bk_waddr     (bk_waddr),
    .bk_wdata     (bk_wdata),
    .bk_wstrb     (bk_wstrb),
    .bk_wack      (bk_wack),
    .bk_rreq      (bk_rreq),
    .bk_raddr     (bk_raddr),
    .bk_rack      (bk_rack),
    .bk_rdata     (bk_rdata),
    .err_wtimeout (err_wtimeout),
    .err_rtimeout (err_rtimeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chkb({tag, "_awready"}, axi.axi_awready, 1'b1);
    chkb({tag, "_wready"}, axi.axi_wready, 1'b1);
    chkb({tag, "_arready"}, axi.axi_arready, 1'b1);
    chkb({tag, "_rvalid"}, axi.axi_rvalid, 1'b0);
    chkb({tag, "_bk_wreq"}, bk_wreq, 1'b0);
    chkb({tag, "_bk_rreq"}, bk_rreq, 1'b0);
    chkb({tag, "_err_w"}, err_wtimeout, 1'b0);
    chkb({tag, "_err_r"}, err_rtimeout, 1'b0);
  endtask

  // order: 0 = AW and W together, 1 = AW then W, 2 = W then AW two cycles later.
  // ack_at: REQ cycle (1-based) in which bk_wack is pulsed; beyond TO means never.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int order, input int ack_at);
    int  wait_n;
    int  k;
    bit  exp_to;
    int  exp_len;
    exp_to  = (ack_at > TO);
    exp_len = exp_to ? TO : ack_at;
    axi.axi_awaddr = a;
    axi.axi_wdata  = d;
    axi.axi_wstrb  = s;
    chkb("wr_awready_pre", axi.axi_awready, 1'b1);
    chkb("wr_wready_pre", axi.axi_wready, 1'b1);
    case (order)
      0: begin
        axi.axi_awvalid = 1'b1;
        axi.axi_wvalid  = 1'b1;
        tick();
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
      end
      1: begin
        axi.axi_awvalid = 1'b1;
        tick();
        axi.axi_awvalid = 1'b0;
        chkb("wr_awready_held", axi.axi_awready, 1'b0);
        tick();
        axi.axi_wvalid = 1'b1;
        tick();
        axi.axi_wvalid = 1'b0;
      end
      default: begin
        axi.axi_wvalid = 1'b1;
        tick();
        axi.axi_wvalid = 1'b0;
        chkb("wr_wready_held", axi.axi_wready, 1'b0);
        tick();
        axi.axi_awvalid = 1'b1;
        tick();
        axi.axi_awvalid = 1'b0;
      end
    endcase
    axi.axi_awaddr = $urandom;
    axi.axi_wdata  = $urandom;
    wait_n = 0;
    while (!bk_wreq && wait_n < 10) begin
      tick();
      wait_n++;
    end
    chk("wr_latency", wait_n, 1);
    k = 0;
    while (bk_wreq && k < 10) begin
      k++;
      chk("bk_waddr", bk_waddr, a);
      chk("bk_wdata", bk_wdata, d);
      chk("bk_wstrb", {28'b0, bk_wstrb}, {28'b0, s});
      if (k == ack_at) bk_wack = 1'b1;
      tick();
      bk_wack = 1'b0;
    end
    chk("wr_req_len", k, exp_len);
    chkb("err_wtimeout", err_wtimeout, exp_to);
    chkb("wr_awready_post", axi.axi_awready, 1'b1);
    chkb("wr_wready_post", axi.axi_wready, 1'b1);
    chk("bk_waddr_idle", bk_waddr, 32'h0);
    chk("bk_wdata_idle", bk_wdata, 32'h0);
    tick();
    chkb("err_wtimeout_pulse", err_wtimeout, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input int ack_at, input int hold,
                         input logic [31:0] bdata);
    int          k;
    bit          exp_to;
    int          exp_len;
    logic [31:0] exp_data;
    exp_to   = (ack_at > TO);
    exp_len  = exp_to ? TO : ack_at;
    exp_data = exp_to ? TO_DATA : bdata;
    chkb("rd_arready_pre", axi.axi_arready, 1'b1);
    axi.axi_araddr  = a;
    axi.axi_arvalid = 1'b1;
    tick();
    axi.axi_arvalid = 1'b0;
    axi.axi_araddr  = $urandom;
    chkb("rd_arready_busy", axi.axi_arready, 1'b0);
    k = 0;
    while (bk_rreq && k < 10) begin
      k++;
      chk("bk_raddr", bk_raddr, a);
      if (k == ack_at) begin
        bk_rack  = 1'b1;
        bk_rdata = bdata;
      end
      tick();
      bk_rack  = 1'b0;
      bk_rdata = $urandom;
    end
    chk("rd_req_len", k, exp_len);
    chkb("rvalid", axi.axi_rvalid, 1'b1);
    chk("rdata", axi.axi_rdata, exp_data);
    chkb("err_rtimeout", err_rtimeout, exp_to);
    chk("bk_raddr_idle", bk_raddr, 32'h0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chkb("rvalid_hold", axi.axi_rvalid, 1'b1);
      chk("rdata_hold", axi.axi_rdata, exp_data);
    end
    axi.axi_rready = 1'b1;
    tick();
    axi.axi_rready = 1'b0;
    chkb("rvalid_done", axi.axi_rvalid, 1'b0);
    chkb("rd_arready_post", axi.axi_arready, 1'b1);
    chkb("err_rtimeout_pulse", err_rtimeout, 1'b0);
    chk("rdata_retained", axi.axi_rdata, exp_data);
  endtask

  initial begin
    rst             = 1'b1;
    axi.axi_awvalid = 1'b0;
    axi.axi_awaddr  = '0;
    axi.axi_wvalid  = 1'b0;
    axi.axi_wdata   = '0;
    axi.axi_wstrb   = '0;
    axi.axi_arvalid = 1'b0;
    axi.axi_araddr  = '0;
    axi.axi_rready  = 1'b0;
    bk_wack         = 1'b0;
    bk_rack         = 1'b0;
    bk_rdata        = '0;

    tick();
    tick();
    chkb("rst_bk_wreq", bk_wreq, 1'b0);
    chkb("rst_bk_rreq", bk_rreq, 1'b0);
    chk("rst_rdata", axi.axi_rdata, 32'h0);
    chk("rst_bk_waddr", bk_waddr, 32'h0);
    chk("rst_bk_raddr", bk_raddr, 32'h0);
    rst = 1'b0;
    tick();
    chk_idle("after_reset");

    // Acks while idle must be ignored
    bk_wack = 1'b1;
    bk_rack = 1'b1;
    tick();
    bk_wack = 1'b0;
    bk_rack = 1'b0;
    tick();
    chk_idle("stray_ack");

    // Directed scenarios
    do_write(32'h3000_0010, 32'h1234_5678, 4'hF, 1, 3);
    do_write(32'h0000_0004, 32'hA5A5_A5A5, 4'h3, 2, 2);
    do_read(32'h3000_0020, 2, 5, 32'hCAFE_F00D);
    do_read(32'h3000_0030, 9, 1, 32'h1111_2222);
    do_write(32'h3000_0040, 32'h5555_AAAA, 4'h9, 0, 9);
    do_read(32'h3000_0050, TO, 0, 32'h0BAD_F00D);
    do_write(32'h3000_0060, 32'h7777_8888, 4'h1, 0, TO);
    do_write(32'h3000_0070, 32'h0101_0202, 4'hC, 0, 1);
    chk_idle("after_directed");

    // Randomized transactions against the timeout-window rule
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write($urandom, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(1, 6)));
      end else begin
        do_read($urandom, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), $urandom);
      end
    end

    // Concurrent read and write, then reset while the read is outstanding
    axi.axi_awaddr  = 32'h1000_0000;
    axi.axi_wdata   = 32'h2222_3333;
    axi.axi_wstrb   = 4'hF;
    axi.axi_araddr  = 32'h1000_0004;
    axi.axi_awvalid = 1'b1;
    axi.axi_wvalid  = 1'b1;
    axi.axi_arvalid = 1'b1;
    tick();
    axi.axi_awvalid = 1'b0;
    axi.axi_wvalid  = 1'b0;
    axi.axi_arvalid = 1'b0;
    tick();
    chkb("conc_bk_wreq", bk_wreq, 1'b1);
    chkb("conc_bk_rreq", bk_rreq, 1'b1);
    chk("conc_bk_raddr", bk_raddr, 32'h1000_0004);
    #2;
    rst = 1'b1;
    #1;
    chkb("midrst_bk_wreq", bk_wreq, 1'b0);
    chkb("midrst_bk_rreq", bk_rreq, 1'b0);
    chk("midrst_rdata", axi.axi_rdata, 32'h0);
    chkb("midrst_rvalid", axi.axi_rvalid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle("post_abort");
    end
    chk("post_abort_rdata", axi.axi_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
